// File: rtl/bus_router_pkg.sv
// Shared types and helpers for the host-to-device address router.
package bus_router_pkg;

  typedef logic [3:0] dev_idx_t;

  localparam dev_idx_t ERR_IDX     = 4'hF;
  localparam int       MAX_DEVICES = 8;

  function automatic logic addr_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/resp_order_fifo.sv
// Small in-order FIFO of device indices; the head tells the router which
// device owns the next host response.
module resp_order_fifo
  import bus_router_pkg::*;
#(
  parameter int Depth = 2,
  parameter int CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  dev_idx_t        push_data_i,
  output dev_idx_t        head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  dev_idx_t        r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_device_router.sv
// Routes host data-port requests to one device by address and returns the
// device responses to the host in issue order; unmapped addresses get an error.
module bus_device_router
  import bus_router_pkg::*;
#(
  parameter int                       NumDevices     = 2,
  parameter int                       MaxOutstanding = 2,
  parameter logic [NumDevices*32-1:0] DevBase        = {32'h0002_0000, 32'h0010_0000},
  parameter logic [NumDevices*32-1:0] DevMask        = {32'hFFFF_FC00, 32'hFFF0_0000}
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       host_req_i,
  input  logic                       host_we_i,
  input  logic [3:0]                 host_be_i,
  input  logic [31:0]                host_addr_i,
  input  logic [31:0]                host_wdata_i,
  output logic                       host_gnt_o,
  output logic                       host_rvalid_o,
  output logic [31:0]                host_rdata_o,
  output logic                       host_err_o,
  output logic [NumDevices-1:0]      dev_req_o,
  output logic                       dev_we_o,
  output logic [3:0]                 dev_be_o,
  output logic [31:0]                dev_addr_o,
  output logic [31:0]                dev_wdata_o,
  input  logic [NumDevices-1:0]      dev_gnt_i,
  input  logic [NumDevices-1:0]      dev_rvalid_i,
  input  logic [NumDevices*32-1:0]   dev_rdata_i,
  input  logic [NumDevices-1:0]      dev_err_i
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  dev_idx_t              w_target;
  dev_idx_t              w_head;
  dev_idx_t              r_last_target;
  logic                  w_err_tgt;
  logic                  w_can_issue;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;
  logic [CntW-1:0]       w_count;
  logic [NumDevices-1:0] w_match;
  logic [NumDevices-1:0] w_head_sel;
  logic [NumDevices-1:0] w_hit;
  logic [NumDevices-1:0] w_stray;
  logic [3:0]            w_stray_num;
  logic                  r_err_pending;
  logic                  r_after_rst;
  logic [7:0]            r_stray_cnt;

  for (genvar gi = 0; gi < NumDevices; gi++) begin : g_dev
    assign w_match[gi]    = addr_match(host_addr_i, DevBase[gi*32 +: 32], DevMask[gi*32 +: 32]);
    assign dev_req_o[gi]  = host_req_i && w_can_issue && (w_target == dev_idx_t'(gi));
    assign w_head_sel[gi] = !w_empty && (w_head == dev_idx_t'(gi));
    assign w_hit[gi]      = w_head_sel[gi] && dev_rvalid_i[gi];
    assign w_stray[gi]    = dev_rvalid_i[gi] && !w_head_sel[gi];
  end

  // Lowest matching index wins on overlapping windows.
  always_comb begin
    w_target = ERR_IDX;
    for (int i = NumDevices - 1; i >= 0; i--) begin
      if (w_match[i]) w_target = dev_idx_t'(i);
    end
  end

  assign w_err_tgt = (w_target == ERR_IDX);

  // Switching targets waits for a fully drained FIFO, so in-order devices
  // alone are enough to keep host responses in issue order.
  assign w_can_issue = !rst_i && (w_count < CntW'(MaxOutstanding)) &&
                       ((w_count == '0) || (w_target == r_last_target));

  assign host_gnt_o  = w_err_tgt ? (host_req_i && w_can_issue) : |(dev_req_o & dev_gnt_i);
  assign w_push      = host_gnt_o && !w_full;

  assign dev_we_o    = host_we_i;
  assign dev_be_o    = host_be_i;
  assign dev_addr_o  = host_addr_i;
  assign dev_wdata_o = host_wdata_i;

  resp_order_fifo #(
    .Depth (MaxOutstanding)
  ) u_order_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .pop_i       (host_rvalid_o),
    .push_data_i (w_target),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  always_comb begin
    host_rvalid_o = 1'b0;
    host_rdata_o  = '0;
    host_err_o    = 1'b0;
    if (!rst_i) begin
      if (!w_empty && (w_head == ERR_IDX) && r_err_pending) begin
        host_rvalid_o = 1'b1;
        host_err_o    = 1'b1;
      end else begin
        for (int i = 0; i < NumDevices; i++) begin
          if (w_hit[i]) begin
            host_rvalid_o = 1'b1;
            host_rdata_o  = dev_rdata_i[i*32 +: 32];
            host_err_o    = dev_err_i[i];
          end
        end
      end
    end
  end

  always_comb begin
    w_stray_num = '0;
    for (int i = 0; i < NumDevices; i++) begin
      w_stray_num = w_stray_num + 4'(w_stray[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_target <= '0;
      r_err_pending <= 1'b0;
      r_after_rst   <= 1'b1;
      r_stray_cnt   <= '0;
    end else begin
      r_after_rst   <= 1'b0;
      r_err_pending <= host_gnt_o && w_err_tgt;
      if (host_gnt_o) r_last_target <= w_target;
      r_stray_cnt   <= r_stray_cnt + 8'(w_stray_num);
    end
  end

  // Late responses from before a reset are expected once; later ones are suspicious.
  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (rst_i || r_after_rst)
                                      w_stray == '0)
    else $warning("bus_device_router: stray device rvalid ignored");

endmodule

// File: tb/tb_bus_device_router.sv
// Scoreboarded bench: device 0 behaves as simulator_ctrl, device 1 as a RAM.
module tb_bus_device_router;
  import bus_router_pkg::*;

  localparam int ND   = 2;
  localparam int MAXO = 2;
  localparam int SC   = 0;
  localparam int RAM  = 1;
  localparam int ERRT = 15;
  localparam logic [ND*32-1:0] BASES = {32'h0010_0000, 32'h0002_0000};
  localparam logic [ND*32-1:0] MASKS = {32'hFFF0_0000, 32'hFFFF_FC00};
  localparam logic [31:0] SC_BASE  = 32'h0002_0000;
  localparam logic [31:0] RAM_BASE = 32'h0010_0000;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              host_req_i, host_we_i;
  logic [3:0]        host_be_i;
  logic [31:0]       host_addr_i, host_wdata_i;
  logic              host_gnt_o, host_rvalid_o, host_err_o;
  logic [31:0]       host_rdata_o;
  logic [ND-1:0]     dev_req_o;
  logic              dev_we_o;
  logic [3:0]        dev_be_o;
  logic [31:0]       dev_addr_o, dev_wdata_o;
  logic [ND-1:0]     dev_gnt_i, dev_rvalid_i, dev_err_i;
  logic [ND*32-1:0]  dev_rdata_i;

  bus_device_router #(
    .NumDevices(ND), .MaxOutstanding(MAXO), .DevBase(BASES), .DevMask(MASKS)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_be_i(host_be_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
    .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_we_o(dev_we_o), .dev_be_o(dev_be_o),
    .dev_addr_o(dev_addr_o), .dev_wdata_o(dev_wdata_o),
    .dev_gnt_i(dev_gnt_i), .dev_rvalid_i(dev_rvalid_i),
    .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i)
  );

  always #5 clk = ~clk;

  typedef struct { int tgt; logic [31:0] rdata; logic err; } exp_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  exp_t        sb[$];
  rsp_t        ram_q[$];
  rsp_t        sc_q[$];
  logic [31:0] ram_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] tb_base [ND] = '{32'h0002_0000, 32'h0010_0000};
  logic [31:0] tb_mask [ND] = '{32'hFFFF_FC00, 32'hFFF0_0000};

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    ram_lat = 2;
  bit    ram_rand = 0;
  int    last_tgt = 0;
  bit    err_due = 0;
  int    stray_model = 0;
  string sc_log = "";
  bit    sim_finish = 0;
  int    finish_cyc = 0;
  logic [3:0]  sc_last_be;
  logic [31:0] sc_last_wdata;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < ND; i++)
      if ((a & tb_mask[i]) == tb_base[i]) return i;
    return ERRT;
  endfunction

  // Reference model and scoreboard, evaluated mid-cycle when everything is settled.
  always @(negedge clk) begin
    int          tgt;
    bit          can, exp_gnt, exp_rv;
    logic [ND-1:0] exp_req;
    exp_t        e;
    logic [31:0] rd;
    if (rst_i) begin
      chk("rst_gnt", host_gnt_o, 0);
      chk("rst_req", dev_req_o, 0);
      chk("rst_rvalid", host_rvalid_o, 0);
      chk("rst_err", host_err_o, 0);
      chk("rst_rdata", host_rdata_o, 0);
      sb.delete();
      last_tgt = 0;
      err_due = 0;
      stray_model = 0;
    end else begin
      tgt = decode(host_addr_i);
      can = (sb.size() < MAXO) && (sb.size() == 0 || tgt == last_tgt);
      exp_req = '0;
      if (host_req_i && can && tgt != ERRT) exp_req[tgt] = 1'b1;
      exp_gnt = host_req_i && can && (tgt == ERRT || dev_gnt_i[tgt]);
      chk("dev_req", dev_req_o, exp_req);
      chk("host_gnt", host_gnt_o, exp_gnt);
      if (exp_gnt) begin
        chk("bcast_addr", dev_addr_o, host_addr_i);
        chk("bcast_wdata", dev_wdata_o, host_wdata_i);
        chk("bcast_be", {dev_we_o, dev_be_o}, {host_we_i, host_be_i});
      end
      exp_rv = 0;
      if (sb.size() > 0)
        exp_rv = (sb[0].tgt == ERRT) ? err_due : dev_rvalid_i[sb[0].tgt];
      for (int i = 0; i < ND; i++)
        if (dev_rvalid_i[i] && !(sb.size() > 0 && sb[0].tgt == i)) stray_model++;
      chk("host_rvalid", host_rvalid_o, exp_rv);
      if (host_rvalid_o && exp_rv) begin
        chk("resp_rdata", host_rdata_o, sb[0].rdata);
        chk("resp_err", host_err_o, sb[0].err);
      end
      if (exp_rv) void'(sb.pop_front());
      err_due = exp_gnt && tgt == ERRT;
      if (exp_gnt) begin
        e.tgt = tgt; e.rdata = '0; e.err = (tgt == ERRT);
        if (tgt == RAM) begin
          if (host_we_i) begin
            for (int b = 0; b < 4; b++)
              if (host_be_i[b]) ref_mem[host_addr_i[9:2]][b*8 +: 8] = host_wdata_i[b*8 +: 8];
          end else e.rdata = ref_mem[host_addr_i[9:2]];
        end
        sb.push_back(e);
        last_tgt = tgt;
      end
    end
    // Device models react to what the router presented this cycle.
    if (dev_req_o[SC] && dev_gnt_i[SC]) begin
      sc_last_be = dev_be_o;
      sc_last_wdata = dev_wdata_o;
      if (dev_we_o && dev_addr_o[9:0] == 10'h000) sc_log = {sc_log, $sformatf("%c", dev_wdata_o[7:0])};
      if (dev_we_o && dev_addr_o[9:0] == 10'h008 && dev_wdata_o[0]) begin
        sim_finish = 1;
        finish_cyc = cyc;
      end
      sc_q.push_back('{due: cyc + 1, data: 32'h0});
    end
    if (dev_req_o[RAM] && dev_gnt_i[RAM]) begin
      rd = '0;
      if (dev_we_o) begin
        for (int b = 0; b < 4; b++)
          if (dev_be_o[b]) ram_mem[dev_addr_o[9:2]][b*8 +: 8] = dev_wdata_o[b*8 +: 8];
      end else rd = ram_mem[dev_addr_o[9:2]];
      ram_q.push_back('{due: cyc + ram_lat, data: rd});
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    dev_rvalid_i = '0;
    dev_rdata_i  = '0;
    dev_err_i    = '0;
    if (sc_q.size() > 0 && sc_q[0].due == cyc) begin
      dev_rvalid_i[SC] = 1'b1;
      dev_rdata_i[SC*32 +: 32] = sc_q[0].data;
      void'(sc_q.pop_front());
    end
    if (ram_q.size() > 0 && ram_q[0].due == cyc) begin
      dev_rvalid_i[RAM] = 1'b1;
      dev_rdata_i[RAM*32 +: 32] = ram_q[0].data;
      void'(ram_q.pop_front());
    end
    dev_gnt_i[SC]  = 1'b1;
    dev_gnt_i[RAM] = ram_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Called just after a rising edge; returns how many cycles the request stalled.
  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, output int stalls);
    bit granted = 0;
    stalls = 0;
    host_req_i = 1'b1; host_we_i = we; host_be_i = be; host_addr_i = addr; host_wdata_i = wd;
    for (int k = 0; k < 100 && !granted; k++) begin
      @(negedge clk);
      if (host_gnt_o) granted = 1;
      else stalls++;
    end
    if (!granted) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: addr %08h never granted", addr);
    end
    @(posedge clk); #1;
    host_req_i = 1'b0;
  endtask

  task automatic drain();
    bit idle = 0;
    for (int k = 0; k < 60 && !idle; k++) begin
      @(negedge clk);
      idle = (sb.size() == 0) && (ram_q.size() == 0) && (sc_q.size() == 0);
    end
    if (!idle) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d responses still expected", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int start;
    rst_i = 1'b1;
    host_req_i = 0; host_we_i = 0; host_be_i = 0; host_addr_i = 0; host_wdata_i = 0;
    dev_gnt_i = '1; dev_rvalid_i = '0; dev_rdata_i = '0; dev_err_i = '0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'hC0DE_0000 ^ (i * 32'h0101_0007);
      ref_mem[i] = ram_mem[i];
    end
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid", host_rvalid_o, 0);
    chk("post_rst_rdata", host_rdata_o, 0);
    @(posedge clk); #1;

    // Character write to simulator_ctrl: granted immediately, response next cycle.
    host_req_i = 1; host_we_i = 1; host_be_i = 4'hF; host_addr_i = SC_BASE; host_wdata_i = 32'h41;
    @(negedge clk);
    chk("t1_req", dev_req_o, 2'b01);
    chk("t1_gnt", host_gnt_o, 1);
    @(posedge clk); #1 host_req_i = 0;
    @(negedge clk);
    chk("t1_rvalid", host_rvalid_o, 1);
    chk("t1_err", host_err_o, 0);
    @(posedge clk); #1;
    n_tests++;
    if (sc_log != "A") begin n_fail++; $display("FAIL t1_log: got '%s' expected 'A'", sc_log); end

    // Two back-to-back RAM reads fill the FIFO; the third waits one cycle past the first rvalid.
    issue(0, 4'hF, RAM_BASE,        0, s); chk("t2_stall1", s, 0);
    issue(0, 4'hF, RAM_BASE + 4,    0, s); chk("t2_stall2", s, 0);
    issue(0, 4'hF, RAM_BASE + 8,    0, s); chk("t2_stall3", s, 1);
    drain();

    // Target switch waits until the RAM read has fully returned.
    issue(0, 4'hF, RAM_BASE + 32'h40, 0, s);    chk("t3_ram", s, 0);
    issue(1, 4'hF, SC_BASE + 32'h10, 32'h5, s); chk("t3_switch", s, 2);
    drain();

    // Unmapped read: error response one cycle after the grant, no device touched.
    host_req_i = 1; host_we_i = 0; host_be_i = 4'hF; host_addr_i = 32'h8000_0000;
    @(negedge clk);
    chk("t4_gnt", host_gnt_o, 1);
    chk("t4_req", dev_req_o, 0);
    @(posedge clk); #1 host_req_i = 0;
    @(negedge clk);
    chk("t4_rvalid", host_rvalid_o, 1);
    chk("t4_err", host_err_o, 1);
    chk("t4_rdata", host_rdata_o, 0);
    @(posedge clk); #1;

    // Reset with two RAM reads in flight; their late rvalids must be dropped.
    ram_lat = 4;
    issue(0, 4'hF, RAM_BASE + 32'hC,  0, s); chk("t5_stall1", s, 0);
    issue(0, 4'hF, RAM_BASE + 32'h10, 0, s); chk("t5_stall2", s, 0);
    rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    drain();
    chk("t5_stray_cnt", dut.r_stray_cnt, stray_model);
    ram_lat = 2;
    issue(0, 4'hF, RAM_BASE + 32'h14, 0, s); chk("t5_after", s, 0);
    drain();

    // Finish request passes through unchanged and reaches the device.
    start = cyc;
    host_req_i = 1; host_we_i = 1; host_be_i = 4'hF; host_addr_i = SC_BASE + 32'h8; host_wdata_i = 32'h1;
    @(negedge clk);
    chk("t6_be", dev_be_o, 4'hF);
    chk("t6_wdata", dev_wdata_o, 32'h1);
    @(posedge clk); #1 host_req_i = 0;
    repeat (2) @(negedge clk);
    chk("t6_finish", {31'b0, sim_finish && (finish_cyc - start) < 3}, 1);
    drain();

    // Randomised mix of RAM, simulator_ctrl and unmapped traffic.
    ram_rand = 1;
    for (int n = 0; n < 200; n++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      if (kind < 6)      a = RAM_BASE + {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      else if (kind < 8) a = SC_BASE + 32'h100 + {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      else               a = 32'h8000_0000 | {12'b0, 18'($urandom), 2'b00};
      issue(1'($urandom), 4'($urandom_range(1, 15)), a, $urandom, s);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    ram_rand = 0;
    drain();
    chk("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
